// File: rtl/iter_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter_if
// Description : Request/response handshake bundle for the iterative shifter.
//               The master side is the issue logic / consumer pair, the
//               slave side is the shift unit itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_shifter_if #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_data;
    logic               busy;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter
// Description : Multi-cycle RV64I shift unit (SLL/SRL/SRA). One operation at
//               a time; the shift amount is applied as a sequence of
//               single-bit steps on a registered datapath.
//               Optional macro ITER_SHIFTER_MULTI_STEP_EN: while at least 8
//               bits remain, a step moves 8 bits at once.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_shifter #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    iter_shifter_if.slave    bus
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    data_q,  data_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]         op_q,    op_d;

    logic [SHAMT_W-1:0] step_amt;
    logic [XLEN-1:0]    step_data;

    // Size of the current shift step: 1 bit, or 8 bits when the wide step
    // is enabled and enough count remains to use it.
    always_comb begin
        step_amt = SHAMT_W'(1);
`ifdef ITER_SHIFTER_MULTI_STEP_EN
        if (cnt_q >= SHAMT_W'(8)) begin
            step_amt = SHAMT_W'(8);
        end
`endif
    end

    // One shift step of the datapath register with the fill rule of op_q.
    always_comb begin
        step_data = data_q;
        case (op_q)
            OP_SLL:  step_data = data_q << step_amt;
            OP_SRL:  step_data = data_q >> step_amt;
            OP_SRA:  step_data = XLEN'($signed(data_q) >>> step_amt);
            default: step_data = data_q;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in SHIFT, hold in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d = bus.in_data;
                    cnt_d  = bus.in_shamt;
                    op_d   = bus.in_op;
                    // Nothing to iterate: result is the operand itself.
                    if ((bus.in_shamt == '0) || (bus.in_op == OP_NONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = step_data;
                // '<=' also closes out a corrupted zero count instead of
                // letting it wrap into a long bogus shift.
                if (cnt_q <= step_amt) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - step_amt;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shifter
// Description : Self-checking bench for iter_shifter. A transaction-level
//               model (operand -> shifted result plus a step countdown) is
//               compared with the DUT every cycle; directed cases pin the
//               model with hand-computed literals, random cases follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shifter;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

`ifdef ITER_SHIFTER_MULTI_STEP_EN
    localparam int LAT63 = 14;   // 7 wide steps + 7 single steps
    localparam int LAT17 = 3;    // 8, 8, 1
`else
    localparam int LAT63 = 63;
    localparam int LAT17 = 17;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    iter_shifter_if #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) bus ();

    iter_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Architectural result of an RV64 shift.
    function automatic logic [63:0] ref_shift(input logic [1:0] op,
                                              input logic [63:0] d,
                                              input logic [5:0] sh);
        case (op)
            2'b01:   return d << sh;
            2'b10:   return d >> sh;
            2'b11:   return 64'($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    // Number of clock edges after the accept edge until out_valid is up.
    // Pass-through ops land in DONE on the accept edge itself, so out_valid
    // is already high in the cycle right after the accept.
    function automatic int ref_steps(input logic [1:0] op, input logic [5:0] sh);
        if (op == 2'b00 || sh == 6'd0) return 0;
`ifdef ITER_SHIFTER_MULTI_STEP_EN
        return int'(sh) / 8 + int'(sh) % 8;
`else
        return int'(sh);
`endif
    endfunction

    task automatic check_val(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy;
    int          m_wait;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_wait <= 0;
            m_res  <= '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy <= 1'b1;
                m_res  <= ref_shift(bus.in_op, bus.in_data, bus.in_shamt);
                m_wait <= ref_steps(bus.in_op, bus.in_shamt);
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (bus.out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check_val("reset out_valid", 64'(bus.out_valid), 64'd0);
            check_val("reset busy",      64'(bus.busy),      64'd0);
            check_val("reset out_data",  bus.out_data,       64'd0);
        end else begin
            check_val("in_ready",  64'(bus.in_ready),  64'(!m_busy));
            check_val("out_valid", 64'(bus.out_valid), 64'(m_busy && m_wait == 0));
            check_val("busy",      64'(bus.busy),      64'(m_busy));
            if (m_busy && m_wait == 0)
                check_val("out_data", bus.out_data, m_res);
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [1:0] op, input logic [63:0] d,
                          input logic [5:0] sh, input int bp, input bit pin,
                          input logic [63:0] exp_d, input int exp_lat);
        int guard;
        int lat;
        @(negedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = sh;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            check_val("accept timeout", 64'(guard), 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Operands are only sampled at the accept edge; scramble them now.
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.in_shamt = 6'($urandom_range(0, 63));
        bus.in_op    = 2'($urandom_range(0, 3));
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) check_val("result timeout", 64'(lat), 64'd0);
        if (pin) begin
            check_val("model pin",     ref_shift(op, d, sh), exp_d);
            check_val("latency",       64'(lat),             64'(exp_lat));
            check_val("result",        bus.out_data,         exp_d);
        end
        repeat (bp) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            if (pin) begin
                check_val("bp out_data", bus.out_data,     exp_d);
                check_val("bp in_ready", 64'(bus.in_ready), 64'd0);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (pin) begin
            check_val("idle in_ready",  64'(bus.in_ready),  64'd1);
            check_val("idle out_valid", 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        run_op(2'b01, 64'h1,                 6'd63, 0, 1'b1, 64'h8000_0000_0000_0000, LAT63);
        run_op(2'b11, 64'h8000_0000_0000_0000, 6'd4, 0, 1'b1, 64'hF800_0000_0000_0000, 4);
        run_op(2'b10, 64'h8000_0000_0000_0000, 6'd4, 0, 1'b1, 64'h0800_0000_0000_0000, 4);
        run_op(2'b01, 64'h1234,              6'd0,  0, 1'b1, 64'h1234,                0);
        run_op(2'b00, 64'hABCD,              6'd9,  0, 1'b1, 64'hABCD,                0);
        run_op(2'b01, 64'h1,                 6'd1,  5, 1'b1, 64'h2,                   1);
        run_op(2'b11, 64'h8000_0000_0000_0000, 6'd63, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, LAT63);
        run_op(2'b01, 64'h1,                 6'd17, 0, 1'b1, 64'h0000_0000_0002_0000, LAT17);

        // Reset three cycles into a 20-bit shift.
        @(negedge clk); #1;
        bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_data = 64'h5; bus.in_shamt = 6'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_val("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid reset busy",      64'(bus.busy),      64'd0);
        check_val("mid reset out_data",  bus.out_data,       64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("after reset in_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) @(negedge clk);
        run_op(2'b10, 64'hF0, 6'd4, 0, 1'b1, 64'h0F, 4);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] sh;
            sh = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            run_op(2'($urandom_range(0, 3)), {$urandom, $urandom}, sh,
                   $urandom_range(0, 3), 1'b0, 64'd0, 0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
